// File: rtl/pwm_duty_if.sv
// Duty-value handshake between the PWM duty source and the compare stage.
interface pwm_duty_if #(
  parameter int CW = 4
);
  logic [CW-1:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_duty_compare.sv
// Duty compare stage behind the mod-PERIOD counter: double-buffered duty, registered PWM.
// Optional complementary output with one-cycle dead time when PWM_DEADTIME_EN is defined.
module pwm_duty_compare #(
  parameter int PERIOD = 14,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  pwm_duty_if.slave     duty,
  input  logic          w,
  input  logic [CW-1:0] q,
  output logic          pwm,
  output logic          pwm_n,
  output logic          period_done,
  output logic          range_err
);

  localparam logic [CW-1:0] PMAX = CW'(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic          reset_n_q;
  logic          pend_full;
  logic          raw;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] duty_pend;
  logic [CW-1:0] duty_sat;
  logic          in_range;
  logic          bnd;
  logic          accept;

  assign in_range        = (q < PMAX);
  assign bnd             = w && in_range && (q == LAST);
  assign duty.duty_ready = reset_n_q && !pend_full;
  assign accept          = duty.duty_valid && duty.duty_ready;
  assign duty_sat        = (duty.duty_in > PMAX) ? PMAX : duty.duty_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reset_n_q   <= 1'b0;
      duty_act    <= '0;
      duty_pend   <= '0;
      pend_full   <= 1'b0;
      raw         <= 1'b0;
      period_done <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      reset_n_q <= 1'b1;
      // Ready is low while full, so a boundary swap and an accept never collide.
      if (bnd && pend_full) begin
        duty_act  <= duty_pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        duty_pend <= duty_sat;
        pend_full <= 1'b1;
      end
      raw         <= in_range && (q < duty_act);
      period_done <= bnd;
      if (!in_range) begin
        range_err <= 1'b1;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  logic raw_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= raw;
    end
  end

  // Both outputs need two agreeing samples, giving one all-off cycle per transition.
  assign pwm   = raw && raw_q;
  assign pwm_n = reset_n_q && !raw && !raw_q;
`else
  assign pwm   = raw;
  assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_compare.sv
// Directed bench for pwm_duty_compare; the bench drives the mod-14 counter itself.
module tb_pwm_duty_compare;
  localparam int PERIOD = 14;
  localparam int CW     = 4;

  logic          clk;
  logic          reset_n;
  logic          w;
  logic [CW-1:0] q;
  logic          pwm;
  logic          pwm_n;
  logic          period_done;
  logic          range_err;

  int checks = 0;
  int errors = 0;
  logic e_prev = 1'b0;
  int n_hi;
  int n_lo;

  pwm_duty_if #(.CW(CW)) dif ();

  pwm_duty_compare #(.PERIOD(PERIOD), .CW(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .duty        (dif.slave),
    .w           (w),
    .q           (q),
    .pwm         (pwm),
    .pwm_n       (pwm_n),
    .period_done (period_done),
    .range_err   (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; the bench counter follows w like the real counter.
  task automatic tick();
    @(posedge clk);
    #1;
    if (w) q = (q == CW'(PERIOD - 1)) ? '0 : q + 1'b1;
  endtask

  // e is the expected compare result registered at the last edge.
  task automatic exp_out(input logic e);
`ifdef PWM_DEADTIME_EN
    chk("pwm", 32'(pwm), 32'(e && e_prev));
    chk("pwm_n", 32'(pwm_n), 32'(!e && !e_prev));
    assert (!(pwm && pwm_n)) else begin
      errors++;
      $error("FAIL overlap observed=%0d%0d expected=not both high", pwm, pwm_n);
    end
`else
    chk("pwm", 32'(pwm), 32'(e));
    chk("pwm_n", 32'(pwm_n), 32'd0);
`endif
    e_prev = e;
  endtask

  task automatic tickchk(input int i, input int d);
    tick();
    exp_out(i < d);
    chk("period_done", 32'(period_done), 32'(i == PERIOD - 1));
  endtask

  task automatic run_span(input int lo, input int hi, input int d);
    for (int i = lo; i <= hi; i++) tickchk(i, d);
  endtask

  initial begin
    reset_n = 1'b0;
    w = 1'b0;
    q = '0;
    dif.duty_in = '0;
    dif.duty_valid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_pwm_n", 32'(pwm_n), 32'd0);
    chk("rst_period_done", 32'(period_done), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    chk("rst_ready", 32'(dif.duty_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    exp_out(1'b0);
    chk("ready_after_release", 32'(dif.duty_ready), 32'd1);

    // Duty 5: active only after the first boundary
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd5;
    tick();
    exp_out(1'b0);
    dif.duty_valid = 1'b0;
    chk("ready_drop_5", 32'(dif.duty_ready), 32'd0);
    w = 1'b1;
    run_span(0, 13, 0);
    chk("ready_rise_5", 32'(dif.duty_ready), 32'd1);
    run_span(0, 13, 5);

    // Duty 0 then 15 (saturates to 14)
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd0;
    run_span(0, 0, 5);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 5);
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd15;
    run_span(0, 0, 0);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 0);
    run_span(0, 13, 14);

    // Back-to-back 3 then 9 mid-period
    run_span(0, 2, 14);
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd3;
    run_span(3, 3, 14);
    chk("ready_drop_3", 32'(dif.duty_ready), 32'd0);
    dif.duty_in = 4'd9;
    run_span(4, 12, 14);
    chk("ready_stall_9", 32'(dif.duty_ready), 32'd0);
    run_span(13, 13, 14);
    chk("ready_rise_3", 32'(dif.duty_ready), 32'd1);
    run_span(0, 0, 3);
    chk("ready_drop_9", 32'(dif.duty_ready), 32'd0);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 3);
    run_span(0, 13, 9);

    // Accept 7 in the boundary cycle while duty 2 is active
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd2;
    run_span(0, 0, 9);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 9);
    run_span(0, 12, 2);
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd7;
    chk("ready_at_bnd", 32'(dif.duty_ready), 32'd1);
    run_span(13, 13, 2);
    dif.duty_valid = 1'b0;
    chk("ready_drop_7", 32'(dif.duty_ready), 32'd0);
    run_span(0, 13, 2);
    chk("ready_rise_7", 32'(dif.duty_ready), 32'd1);
    run_span(0, 13, 7);

    // Out-of-range count
    run_span(0, 2, 7);
    q = 4'd14;
    tick();
    exp_out(1'b0);
    chk("range_period_done", 32'(period_done), 32'd0);
    chk("range_err_set", 32'(range_err), 32'd1);
    q = 4'd3;
    run_span(3, 13, 7);
    chk("range_err_sticky", 32'(range_err), 32'd1);

    // w low at q=13: no boundary, pending value waits
    run_span(0, 12, 7);
    w = 1'b0;
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd1;
    tick();
    exp_out(1'b0);
    chk("hold_period_done", 32'(period_done), 32'd0);
    dif.duty_valid = 1'b0;
    chk("hold_ready_drop", 32'(dif.duty_ready), 32'd0);
    repeat (4) begin
      tick();
      exp_out(1'b0);
      chk("hold_period_done", 32'(period_done), 32'd0);
      chk("hold_ready", 32'(dif.duty_ready), 32'd0);
    end
    w = 1'b1;
    run_span(13, 13, 7);
    chk("hold_ready_rise", 32'(dif.duty_ready), 32'd1);
    run_span(0, 13, 1);

    // Reset mid-period with duty 10 active
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd10;
    run_span(0, 0, 1);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 1);
    run_span(0, 4, 10);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_pwm", 32'(pwm), 32'd0);
    chk("mid_rst_pwm_n", 32'(pwm_n), 32'd0);
    chk("mid_rst_period_done", 32'(period_done), 32'd0);
    chk("mid_rst_range_err", 32'(range_err), 32'd0);
    chk("mid_rst_ready", 32'(dif.duty_ready), 32'd0);
    chk("mid_rst_duty_act", 32'(dut.duty_act), 32'd0);
    e_prev = 1'b0;
    reset_n = 1'b1;
    q = '0;
    tick();
    exp_out(1'b0);
    chk("mid_rst_ready_rise", 32'(dif.duty_ready), 32'd1);
    run_span(1, 13, 0);
    run_span(0, 13, 0);

    // Duty 6: high-time count of both outputs over one period
    dif.duty_valid = 1'b1;
    dif.duty_in = 4'd6;
    run_span(0, 0, 0);
    dif.duty_valid = 1'b0;
    run_span(1, 13, 0);
    n_hi = 0;
    n_lo = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tickchk(i, 6);
      if (pwm) n_hi++;
      if (pwm_n) n_lo++;
    end
`ifdef PWM_DEADTIME_EN
    chk("duty6_pwm_count", 32'(n_hi), 32'd5);
    chk("duty6_pwm_n_count", 32'(n_lo), 32'd7);
`else
    chk("duty6_pwm_count", 32'(n_hi), 32'd6);
    chk("duty6_pwm_n_count", 32'(n_lo), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
